seq_chunk_comparator: RTL and testbench
=======================================

Name: seq_chunk_comparator

Overview:
- Multi-cycle magnitude comparator for WIDTH-bit operands A and B.
- Compares CHUNK bits per clock, MSB chunk first, and stops at the first unequal chunk.
- Cascade inputs l/e/g decide the result when all chunks are equal, so instances chain like the fixed-width combinational comparators.
- Sits between operand producers and control logic; uses valid/ready on both input and result sides.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- l  input  1  cascade "less" from lower-significance stage
- e  input  1  cascade "equal"
- g  input  1  cascade "greater"
- in_valid  input  1  operands and cascade inputs valid
- in_ready  output  1  block can accept operands
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- lt  output  1  A < B
- et  output  1  A == B
- gt  output  1  A > B
- busy  output  1  comparison in progress

Behaviour:
- Derived values: NCHUNK = WIDTH/CHUNK; the index counter is clog2(NCHUNK) bits, minimum 1.
- Reset (async on rst_n low): state IDLE; out_valid=0; lt=et=gt=0; busy=0; operand registers cleared.
- Reset released mid-operation: the comparison is aborted and no out_valid is produced.
- State IDLE:
  - in_ready=1.
  - When in_valid=1, register A, B, l, e, g.
  - Set idx=NCHUNK-1 and go to CMP.
- State CMP:
  - busy=1, in_ready=0.
  - Compare registered chunks A[idx*CHUNK +: CHUNK] and B[idx*CHUNK +: CHUNK], unsigned.
  - Chunks differ: register lt/gt from the chunk comparison, et=0, go to DONE.
  - Chunks equal and idx==0: register the cascade result, go to DONE.
  - Otherwise: idx decrements and the state stays CMP.
- Cascade resolution gives one-hot outputs:
  - g=1 -> gt.
  - else l=1 -> lt.
  - else -> et. This covers e=1 and all-zero inputs.
- State DONE:
  - out_valid=1; lt/et/gt held stable and exactly one-hot.
  - When out_ready=1, out_valid drops next cycle and the state goes to IDLE.
  - New operands are accepted only from IDLE, so there is one transaction in flight.
- Latency from the accept edge to out_valid=1 is k cycles, k = number of chunks examined (1..NCHUNK).
- in_valid is ignored outside IDLE; A/B changes after acceptance have no effect.
- Throughput: at most one result per k+2 cycles (accept, k compares, handshake).

Optional Feature:
- Macro: SIGNED_CMP_EN.
- Defined: operands are two's complement; the MSB chunk (idx=NCHUNK-1) is compared signed and lower chunks unsigned.
- Not defined: all chunks are compared unsigned.
- Timing and handshake are identical in both builds.

Decomposition:
- Shared package seq_cmp_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_CMP=2'd1, ST_DONE=2'd2;
  - one-hot result constants RES_LT=3'b100, RES_EQ=3'b010, RES_GT=3'b001.
- Sub-module chunk_cmp: combinational CHUNK-bit comparator with a signed_msb input, producing lt/eq/gt.
  - Instantiated once and fed by the idx mux.

Test Plan (WIDTH=16, CHUNK=4):
- A=16'h1234, B=16'h1234, e=1: out_valid 4 cycles after accept with et=1, lt=gt=0.
- A=16'h1234, B=16'h1234, l=1, e=0: lt=1 after 4 cycles, showing cascade priority. With g=l=1: gt=1. With l=e=g=0: et=1.
- A=16'h8000, B=16'h7FFF: result after 1 cycle; gt=1 unsigned, lt=1 with SIGNED_CMP_EN.
- A=16'h1235, B=16'h1234: gt=1 after 4 cycles. A=16'h0100, B=16'h0200: lt=1 after 2 cycles.
- Backpressure: out_ready=0 for 3 cycles -> out_valid and lt/et/gt held stable, in_ready=0. Release -> IDLE next cycle and a back-to-back transaction is accepted.
- rst_n asserted low during CMP (idx=2) -> outputs 0 immediately. After release: IDLE, in_ready=1, no spurious out_valid.

Source files
------------

// File: rtl/seq_cmp_pkg.sv
// Shared encodings for the chunked sequential comparator: FSM states,
// one-hot {lt,et,gt} result codes and the cascade-input resolver.
package seq_cmp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] RES_LT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_GT = 3'b001;

  // g outranks l; anything else (e alone, or nothing asserted) resolves to equal
  function automatic logic [2:0] cascade_res(input logic l, input logic e, input logic g);
    logic [2:0] r;
    casez ({g, l, e})
      3'b1??:  r = RES_GT;
      3'b01?:  r = RES_LT;
      default: r = RES_EQ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational CHUNK-bit magnitude compare; signed_msb selects a two's
// complement compare for the most significant chunk.
module chunk_cmp #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             signed_msb,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  always_comb begin
    eq = (a == b);
    if (signed_msb) lt = ($signed(a) < $signed(b));
    else            lt = (a < b);
    gt = !eq && !lt;
  end

endmodule

// File: rtl/seq_chunk_comparator.sv
// Multi-cycle A/B comparator, one CHUNK per clock MSB-first, early exit on the
// first unequal chunk. SIGNED_CMP_EN makes the top chunk a signed compare.
module seq_chunk_comparator
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             l,
  input  logic             e,
  input  logic             g,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             et,
  output logic             gt,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [2:0]       casc_r;
  logic [2:0]       res;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             signed_msb;
  logic             c_lt, c_eq, c_gt;

  // Constant-select mux keeps the chunk pick free of wide index arithmetic
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IW'(i)) begin
        a_chunk = a_r[i*CHUNK +: CHUNK];
        b_chunk = b_r[i*CHUNK +: CHUNK];
      end
    end
  end

`ifdef SIGNED_CMP_EN
  assign signed_msb = (idx == IW'(NCHUNK - 1));
`else
  assign signed_msb = 1'b0;
`endif

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a          (a_chunk),
    .b          (b_chunk),
    .signed_msb (signed_msb),
    .lt         (c_lt),
    .eq         (c_eq),
    .gt         (c_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      casc_r <= '0;
      res    <= '0;
      idx    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_r    <= A;
            b_r    <= B;
            casc_r <= cascade_res(l, e, g);
            idx    <= IW'(NCHUNK - 1);
            state  <= ST_CMP;
          end
        end
        ST_CMP: begin
          if (!c_eq) begin
            res   <= c_lt ? RES_LT : (c_gt ? RES_GT : RES_EQ);
            state <= ST_DONE;
          end else if (idx == '0) begin
            res   <= casc_r;
            state <= ST_DONE;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready     = (state == ST_IDLE);
  assign busy         = (state == ST_CMP);
  assign out_valid    = (state == ST_DONE);
  assign {lt, et, gt} = res;

endmodule

// File: tb/tb_seq_chunk_comparator.sv
// Bench for seq_chunk_comparator: directed vector table, backpressure and
// mid-compare reset sequences, then random operands against a full-width model.
module tb_seq_chunk_comparator;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] A, B;
  logic             l, e, g;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic             lt, et, gt, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_chunk_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .l         (l),
    .e         (e),
    .g         (g),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lt        (lt),
    .et        (et),
    .gt        (gt),
    .busy      (busy)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             l;
    logic             e;
    logic             g;
    logic [2:0]       res;   // {lt,et,gt}
    int               lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Whole-operand reference: latency from the highest differing chunk, result
  // from a plain full-width compare, cascade only when the operands are equal.
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic cl, input logic ce, input logic cg,
                                output logic [2:0] res, output int lat);
    logic [WIDTH-1:0] diff;
    bit less;
    diff = a ^ b;
    lat  = NCHUNK;
    for (int i = NCHUNK - 1; i >= 0; i--) begin
      if (((diff >> (i * CHUNK)) & WIDTH'((1 << CHUNK) - 1)) != 0) begin
        lat = NCHUNK - i;
        break;
      end
    end
    if (a == b) begin
      if (cg)      res = 3'b001;
      else if (cl) res = 3'b100;
      else         res = 3'b010;
      if (ce && 1'b0) res = 3'b000;
    end else begin
`ifdef SIGNED_CMP_EN
      less = ($signed(a) < $signed(b));
`else
      less = (a < b);
`endif
      res = less ? 3'b100 : 3'b001;
    end
  endfunction

  // Called and returns just after a falling edge so transactions run back-to-back
  task automatic run_txn(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cl, input logic ce, input logic cg,
                         input logic [2:0] exp_res, input int exp_lat, input int hold);
    int cyc;
    logic [2:0] got;
    chk({name, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    A = a; B = b; l = cl; e = ce; g = cg;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    A = ~a; B = a; l = ~cl; g = ~cg;
    chk({name, ".busy"}, 32'({busy, in_ready}), 32'b10);
    cyc = 0;
    while (!out_valid && cyc < NCHUNK + 3) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    chk({name, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({name, ".latency"}, 32'(cyc), 32'(exp_lat));
    got = {lt, et, gt};
    chk({name, ".result"}, 32'(got), 32'(exp_res));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk({name, ".hold"}, 32'({out_valid, in_ready, lt, et, gt}), 32'({1'b1, 1'b0, exp_res}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, ".release"}, 32'({out_valid, in_ready, busy}), 32'b010);
  endtask

  vec_t vecs[$];

  initial begin
    logic [2:0]       mres;
    int               mlat;
    logic [WIDTH-1:0] ra, rb;
    logic             rl, re, rg;
    int               pos;

    vecs.push_back('{16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 3'b010, 4});
    vecs.push_back('{16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0, 3'b100, 4});
    vecs.push_back('{16'h1234, 16'h1234, 1'b1, 1'b0, 1'b1, 3'b001, 4});
    vecs.push_back('{16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 3'b010, 4});
`ifdef SIGNED_CMP_EN
    vecs.push_back('{16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 3'b100, 1});
    vecs.push_back('{16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 3'b001, 1});
`else
    vecs.push_back('{16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 3'b001, 1});
    vecs.push_back('{16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 3'b100, 1});
`endif
    vecs.push_back('{16'h1235, 16'h1234, 1'b1, 1'b0, 1'b0, 3'b001, 4});
    vecs.push_back('{16'h0100, 16'h0200, 1'b0, 1'b0, 1'b1, 3'b100, 2});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 3'b001, 4});
    vecs.push_back('{16'hA5C3, 16'hA5D3, 1'b0, 1'b1, 1'b0, 3'b100, 3});

    rst_n = 1'b0; A = '0; B = '0; l = 0; e = 0; g = 0;
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.outputs", 32'({out_valid, busy, lt, et, gt}), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].l, vecs[i].e, vecs[i].g,
              vecs[i].res, vecs[i].lat, 0);

    // Backpressure held 3 cycles, then a back-to-back transaction
    run_txn("bp", 16'h1235, 16'h1234, 1'b0, 1'b1, 1'b0, 3'b001, 4, 3);
    run_txn("b2b", 16'h0100, 16'h0200, 1'b0, 1'b1, 1'b0, 3'b100, 2, 0);

    // Reset asserted while comparing chunk index 2
    A = 16'h1234; B = 16'h1234; l = 0; e = 1; g = 0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.outputs", 32'({out_valid, busy, lt, et, gt}), 32'd0);
    chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid.no_out_valid", 32'({out_valid, busy, in_ready}), 32'b001);
    end

    // Random operands, often sharing high chunks to spread the latency
    for (int t = 0; t < 60; t++) begin
      ra = WIDTH'($urandom);
      rb = ra;
      if ($urandom_range(0, 3) == 0) begin
        rb = WIDTH'($urandom);
      end else if ($urandom_range(0, 4) != 0) begin
        pos = $urandom_range(0, NCHUNK - 1);
        rb[pos*CHUNK +: CHUNK] = CHUNK'($urandom);
      end
      rl = 1'($urandom); re = 1'($urandom); rg = 1'($urandom);
      model(ra, rb, rl, re, rg, mres, mlat);
      run_txn($sformatf("rnd%0d", t), ra, rb, rl, re, rg, mres, mlat, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
